// File: rtl/sa_drain.sv
// rtl/sa_drain.sv - systolic-array bottom-edge drain: per-column deskew into an output row FIFO
module sa_drain #(
    parameter int SA_COLS = 4,
    parameter int C_WIDTH = 16,
    parameter int DEPTH   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [SA_COLS-1:0]                i_ctrl_sa_send_data,
    input  logic [SA_COLS-1:0][C_WIDTH-1:0]   i_c,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [SA_COLS-1:0][C_WIDTH-1:0]   o_data,
    output logic                              o_full,
    output logic                              o_overflow,
    output logic                              o_skew_err,
    output logic [15:0]                       o_row_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef logic [SA_COLS-1:0][C_WIDTH-1:0] row_t;

    // Column j ignores its input for j cycles after reset so a row cut by reset leaves no trace.
    logic [SA_COLS-2:0] arm_q, arm_d;
    logic [SA_COLS-1:0] in_v;
    logic [SA_COLS-1:0] dsk_v;
    row_t               dsk_d;

    always_comb begin
        arm_d    = arm_q << 1;
        arm_d[0] = 1'b1;
        in_v     = i_ctrl_sa_send_data;
        for (int j = 1; j < SA_COLS; j++) begin
            in_v[j] = i_ctrl_sa_send_data[j] & arm_q[j-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) arm_q <= '0;
        else       arm_q <= arm_d;
    end

    for (genvar j = 0; j < SA_COLS; j++) begin : g_col
        localparam int D = SA_COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign dsk_v[j] = in_v[j];
            assign dsk_d[j] = i_c[j];
        end else begin : g_dly
            logic [D-1:0]              v_q, v_d;
            logic [D-1:0][C_WIDTH-1:0] d_q, d_d;

            always_comb begin
                v_d    = v_q;
                d_d    = d_q;
                v_d[0] = in_v[j];
                d_d[0] = i_c[j];
                for (int k = 1; k < D; k++) begin
                    v_d[k] = v_q[k-1];
                    d_d[k] = d_q[k-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            assign dsk_v[j] = v_q[D-1];
            assign dsk_d[j] = d_q[D-1];
        end
    end

    row_t          mem_q [DEPTH];
    row_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [OW-1:0] occ_q, occ_d;
    row_t          data_q, data_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d, skew_q, skew_d;
    logic          av, pop, full, we;

    always_comb begin
        av       = dsk_v[0];
        full     = (occ_q == OW'(DEPTH));
        pop      = (occ_q != '0) && i_ready;
        we       = av && (!full || pop);
        rd_nxt   = rd_ptr_q + 1'b1;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        skew_d   = skew_q;

        if (we) begin
            mem_d[wr_ptr_q] = dsk_d;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            cnt_d           = cnt_q + 16'd1;
        end
        if (av && !we)                  ovf_d  = 1'b1;
        if (dsk_v != {SA_COLS{av}})     skew_d = 1'b1;
        if (pop)                        rd_ptr_d = rd_nxt;

        // Head register refreshes only when the visible row actually changes.
        if (pop && occ_q > OW'(1))
            data_d = mem_q[rd_nxt];
        else if (we && (occ_q == '0 || (pop && occ_q == OW'(1))))
            data_d = dsk_d;

        if (we && !pop)      occ_d = occ_q + 1'b1;
        else if (!we && pop) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            skew_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            skew_q   <= skew_d;
        end
    end

    assign o_valid    = (occ_q != '0);
    assign o_full     = full;
    assign o_data     = data_q;
    assign o_overflow = ovf_q;
    assign o_skew_err = skew_q;
    assign o_row_cnt  = cnt_q;

endmodule

// File: tb/tb_sa_drain.sv
// tb/tb_sa_drain.sv - scoreboard bench for sa_drain: skewed row driver, popping monitor
module tb_sa_drain;

    localparam int N = 4;
    localparam int W = 16;

    typedef logic [N-1:0][W-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] vld;
    row_t        cdat;
    logic        ready;
    logic        o_valid, o_full, o_overflow, o_skew_err;
    row_t        o_data;
    logic [15:0] o_row_cnt;

    int   checks = 0;
    int   errors = 0;
    row_t exp_q[$];
    logic hv [N];
    row_t hd [N];
    int   late_col = -1;

    sa_drain #(.SA_COLS(N), .C_WIDTH(W), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ctrl_sa_send_data(vld), .i_c(cdat),
        .o_valid(o_valid), .i_ready(ready), .o_data(o_data),
        .o_full(o_full), .o_overflow(o_overflow), .o_skew_err(o_skew_err),
        .o_row_cnt(o_row_cnt)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input int id);
        row_t r;
        for (int j = 0; j < N; j++) r[j] = W'(id * 4 + j);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Column j presents the row issued j cycles earlier (late_col one extra cycle).
    task automatic step(input logic v, input row_t r);
        for (int k = N - 1; k > 0; k--) begin
            hv[k] = hv[k-1];
            hd[k] = hd[k-1];
        end
        hv[0] = v;
        hd[0] = v ? r : '0;
        for (int j = 0; j < N; j++) begin
            int s;
            s = (j == late_col) ? j + 1 : j;
            vld[j]  = hv[s];
            cdat[j] = hd[s][j];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        vld  = '0;
        cdat = '0;
        for (int k = 0; k < N; k++) begin
            hv[k] = 1'b0;
            hd[k] = '0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && o_valid === 1'b1 && ready === 1'b1) begin
            row_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected no row", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", o_data, e);
                end
            end
        end
    end

    initial begin
        row_t e;
        ready = 1'b1;
        reset_dut();
        check("rst_valid", o_valid, 0);
        check("rst_full", o_full, 0);
        check("rst_data", o_data, 0);
        check("rst_cnt", o_row_cnt, 0);
        check("rst_flags", {o_overflow, o_skew_err}, 0);

        // single row, latency SA_COLS
        exp_q.push_back(mk(64));
        step(1'b1, mk(64));
        check("lat_t1", o_valid, 0);
        idle(1); check("lat_t2", o_valid, 0);
        idle(1); check("lat_t3", o_valid, 0);
        idle(1); check("lat_t4", o_valid, 1);
        check("lat_data", o_data, 64'h0103_0102_0101_0100);
        idle(1); check("lat_t5", o_valid, 0);
        check("single_cnt", o_row_cnt, 1);
        check("single_flags", {o_overflow, o_skew_err}, 0);

        // six rows into a stalled FIFO
        reset_dut();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(mk(100 + i));
            step(1'b1, mk(100 + i));
        end
        idle(6);
        check("ovf_full", o_full, 1);
        check("ovf_flag", o_overflow, 1);
        check("ovf_cnt", o_row_cnt, 4);
        ready = 1'b1;
        idle(4);
        check("ovf_drained", o_valid, 0);
        check("ovf_q_empty", exp_q.size(), 0);

        // write and pop on the same edge while full
        reset_dut();
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(mk(200 + i));
            step(1'b1, mk(200 + i));
        end
        ready = 1'b1;
        check("wp_full0", o_full, 1);
        idle(1); check("wp_full1", o_full, 1);
        idle(1); check("wp_full2", o_full, 1);
        idle(6);
        check("wp_ovf", o_overflow, 0);
        check("wp_cnt", o_row_cnt, 7);
        check("wp_q_empty", exp_q.size(), 0);

        // column 2 one cycle late
        reset_dut();
        late_col = 2;
        e = mk(300);
        e[2] = '0;
        exp_q.push_back(e);
        step(1'b1, mk(300));
        idle(6);
        late_col = -1;
        check("skew_flag", o_skew_err, 1);
        check("skew_cnt", o_row_cnt, 1);
        idle(3);
        check("skew_sticky", o_skew_err, 1);
        check("skew_q_empty", exp_q.size(), 0);

        // reset in the middle of a row
        reset_dut();
        step(1'b1, mk(400));
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_valid", o_valid, 0);
            idle(1);
        end
        check("mid_rst_cnt", o_row_cnt, 0);
        check("mid_rst_flags", {o_overflow, o_skew_err}, 0);

        // long back-to-back stream: row counter wraps
        reset_dut();
        for (int i = 0; i < 65540; i++) begin
            exp_q.push_back(mk(i));
            step(1'b1, mk(i));
        end
        idle(6);
        check("wrap_cnt", o_row_cnt, 4);
        check("wrap_ovf", o_overflow, 0);
        check("wrap_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
